// File: rtl/decoder_pkg.sv
// decoder_pkg: shared definitions for decoder_seq_onehot.
//   MODE_*  : encodings of the 2-bit mode input
//   state_t : controller states IDLE / DECODE / RUN
package decoder_pkg;

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_DECODE = 2'b01;
  localparam logic [1:0] MODE_SEQ    = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    RUN    = 2'd2
  } state_t;

endpackage

// File: rtl/decoder_seq_onehot_decode.sv
// onehot_decode: combinational binary index -> one-hot vector.
//   i_idx    [SEL_WIDTH]      binary index
//   o_onehot [2**SEL_WIDTH]   one-hot result, bit i_idx set
module onehot_decode #(
  parameter int SEL_WIDTH = 4
) (
  input  logic [SEL_WIDTH-1:0]      i_idx,
  output logic [(2**SEL_WIDTH)-1:0] o_onehot
);

  localparam int OUT_WIDTH = 2 ** SEL_WIDTH;

  assign o_onehot = OUT_WIDTH'(1) << i_idx;

endmodule

// File: rtl/decoder_seq_onehot.sv
// decoder_seq_onehot: registered one-hot decoder with a T-state sequencer mode.
//   clk, rst_n   clock, async active-low reset
//   enable_bit   0 forces all outputs to zero
//   mode         00 off, 01 decode, 10 sequence, 11 treated as off
//   select_bits  decode index, or load target in sequence mode
//   load/step/clear  sequence controls (clear > load > step)
//   out          registered one-hot (or zero), index its binary position
//   valid        out holds a one-hot value
//   wrap         one-cycle pulse after a step from LAST_INDEX back to 0
//
// state  | meaning
// IDLE   | disabled or mode off/reserved; all outputs zero
// DECODE | out follows 1 << select_bits, one cycle late
// RUN    | sequencer walking T0..T(LAST_INDEX)
module decoder_seq_onehot
  import decoder_pkg::*;
#(
  parameter int SEL_WIDTH  = 4,
  parameter int LAST_INDEX = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable_bit,
  input  logic [1:0]                mode,
  input  logic [SEL_WIDTH-1:0]      select_bits,
  input  logic                      load,
  input  logic                      step,
  input  logic                      clear,
  output logic [(2**SEL_WIDTH)-1:0] out,
  output logic [SEL_WIDTH-1:0]      index,
  output logic                      valid,
  output logic                      wrap
);

  localparam int OUT_WIDTH = 2 ** SEL_WIDTH;
  localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(LAST_INDEX);

  state_t                 r_state, w_state_nxt;
  logic [SEL_WIDTH-1:0]   r_index, w_index_nxt;
  logic [OUT_WIDTH-1:0]   r_out, w_out_nxt;
  logic                   r_valid, w_valid_nxt;
  logic                   r_wrap, w_wrap_nxt;
  logic [OUT_WIDTH-1:0]   w_onehot;

  onehot_decode #(.SEL_WIDTH(SEL_WIDTH)) u_onehot_decode (
    .i_idx    (w_index_nxt),
    .o_onehot (w_onehot)
  );

  always_comb begin
    w_state_nxt = IDLE;
    w_index_nxt = '0;
    w_valid_nxt = 1'b0;
    w_wrap_nxt  = 1'b0;

    if (!enable_bit || mode == MODE_OFF || mode == MODE_RSVD) begin
      w_state_nxt = IDLE;
    end else if (mode == MODE_DECODE) begin
      w_state_nxt = DECODE;
      w_index_nxt = select_bits;
      w_valid_nxt = 1'b1;
    end else if (r_state != RUN) begin
      // Entry always starts at T0; sequencer controls on this cycle are ignored.
      w_state_nxt = RUN;
      w_valid_nxt = 1'b1;
    end else begin
      w_state_nxt = RUN;
      w_valid_nxt = 1'b1;
      w_index_nxt = r_index;
      if (clear) begin
        w_index_nxt = '0;
      end else if (load) begin
        w_index_nxt = (select_bits <= LAST_IDX) ? select_bits : '0;
      end else if (step) begin
        if (r_index == LAST_IDX) begin
          w_index_nxt = '0;
          w_wrap_nxt  = 1'b1;
        end else begin
          w_index_nxt = r_index + SEL_WIDTH'(1);
        end
      end
    end

    w_out_nxt = w_valid_nxt ? w_onehot : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_index <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_index <= w_index_nxt;
      r_out   <= w_out_nxt;
      r_valid <= w_valid_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign out   = r_out;
  assign index = r_index;
  assign valid = r_valid;
  assign wrap  = r_wrap;

endmodule
